// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO address/flag controller.
package fifo_pkg;

  // Registered status flags. All of them update on the same edge as the level.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  // Flag values after reset or flush. almost_empty is 1 because the lowest
  // legal threshold is 0. almost_full is 0 because the lowest legal threshold is 1.
  localparam fifo_flags_t FLAGS_RESET = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

  // Occupancy update, done in 32 bits so the caller truncates once.
  // The callers guarantee that level never goes below 0 or above DEPTH.
  function automatic int unsigned next_level(input int unsigned level,
                                             input logic        wr_ok,
                                             input logic        rd_ok);
    return level + 32'(wr_ok) - 32'(rd_ok);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Wrapping address counter: it counts 0..DEPTH-1 and then returns to 0.
// It works for any DEPTH, not only powers of two.
module fifo_ptr_wrap #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2**WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             INCR,
  output logic [WIDTH-1:0] ADDR
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_ptr_wrap: WIDTH must be at least 1");
  end
  if (DEPTH < 2 || DEPTH > 2**WIDTH) begin : g_bad_depth
    $error("fifo_ptr_wrap: DEPTH must be in 2..2**WIDTH");
  end

  // The address register. A flush takes priority over an increment.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ADDR <= '0;
    end else if (CLR) begin
      ADDR <= '0;
    end else if (INCR) begin
      ADDR <= (ADDR == LAST) ? '0 : ADDR + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_addr_ctrl_sync.sv
// Single-clock FIFO controller. It drives the write and read addresses of an
// external dual-port RAM. It also keeps the fill level, the threshold flags
// and the sticky error flags.
//
// Handshake: WEN and REN are requests. A request is taken on the rising edge
// only when the registered FULL or EMPTY flag allows it: a write is taken when
// WEN=1 and FULL=0, and a read is taken when REN=1 and EMPTY=0. A request that
// is refused has no effect except to set OVERFLOW or UNDERFLOW. CLR overrides
// both requests.
module fifo_addr_ctrl_sync
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DEPTH         = 2**ADDR_WIDTH,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WEN,
  input  logic                  REN,
  input  logic                  CLR,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH-1:0] R_ADDR,
  output logic [ADDR_WIDTH:0]   LEVEL,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int LVL_W = ADDR_WIDTH + 1;
  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AFULL_L  = LVL_W'(AFULL_THRESH);
  localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY_THRESH);

  if (ADDR_WIDTH < 1) begin : g_bad_aw
    $error("fifo_addr_ctrl_sync: ADDR_WIDTH must be at least 1");
  end
  if (DEPTH < 2 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
    $error("fifo_addr_ctrl_sync: DEPTH must be in 2..2**ADDR_WIDTH");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("fifo_addr_ctrl_sync: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_addr_ctrl_sync: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  fifo_flags_t      flags_q;
  fifo_flags_t      flags_d;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             wr_ok;
  logic             rd_ok;

  // Decide which requests are taken. This uses only the registered flags,
  // so a write cannot pass through when FULL and a read cannot pass through when EMPTY.
  always_comb begin
    wr_ok = WEN & ~flags_q.full  & ~CLR;
    rd_ok = REN & ~flags_q.empty & ~CLR;
  end

  // Next level and next flags. All flags come from the next level, never from
  // the pointers, so they stay correct when DEPTH is not a power of two.
  always_comb begin
    level_d = '0;
    flags_d = FLAGS_RESET;
    if (!CLR) begin
      level_d              = LVL_W'(next_level(32'(level_q), wr_ok, rd_ok));
      flags_d.full         = (level_d == DEPTH_L);
      flags_d.empty        = (level_d == '0);
      flags_d.almost_full  = (level_d >= AFULL_L);
      flags_d.almost_empty = (level_d <= AEMPTY_L);
      flags_d.overflow     = flags_q.overflow  | (WEN & flags_q.full);
      flags_d.underflow    = flags_q.underflow | (REN & flags_q.empty);
    end
  end

  // Level and flag registers. They share one edge so they always agree.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      level_q <= '0;
      flags_q <= FLAGS_RESET;
    end else begin
      level_q <= level_d;
      flags_q <= flags_d;
    end
  end

  fifo_ptr_wrap #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (CLR),
    .INCR  (wr_ok),
    .ADDR  (W_ADDR)
  );

  fifo_ptr_wrap #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (CLR),
    .INCR  (rd_ok),
    .ADDR  (R_ADDR)
  );

  // Drive the output ports from the registered state.
  always_comb begin
    LEVEL        = level_q;
    FULL         = flags_q.full;
    EMPTY        = flags_q.empty;
    ALMOST_FULL  = flags_q.almost_full;
    ALMOST_EMPTY = flags_q.almost_empty;
    OVERFLOW     = flags_q.overflow;
    UNDERFLOW    = flags_q.underflow;
  end

endmodule

// File: tb/tb_fifo_addr_ctrl_sync.sv
// Bench for fifo_addr_ctrl_sync with DEPTH=6, ADDR_WIDTH=3, AFULL_THRESH=4
// and AEMPTY_THRESH=2.
module tb_fifo_addr_ctrl_sync;

  localparam int AW = 3;
  localparam int D  = 6;
  localparam int AF = 4;
  localparam int AE = 2;
  localparam int W  = 2*AW + (AW+1) + 6;

  // Clock and reset
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic WEN = 1'b0;
  logic REN = 1'b0;
  logic CLR = 1'b0;
  logic [AW-1:0] W_ADDR, R_ADDR;
  logic [AW:0]   LEVEL;
  logic FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;

  always #5 CLK = ~CLK;

  fifo_addr_ctrl_sync #(
    .ADDR_WIDTH    (AW),
    .DEPTH         (D),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .WEN          (WEN),
    .REN          (REN),
    .CLR          (CLR),
    .W_ADDR       (W_ADDR),
    .R_ADDR       (R_ADDR),
    .LEVEL        (LEVEL),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model, kept as plain integers
  int m_w = 0, m_r = 0, m_lvl = 0;
  bit m_ovf = 0, m_udf = 0;

  function automatic logic [W-1:0] model_vec();
    logic [W-1:0] v;
    v = {AW'(m_w), AW'(m_r), (AW+1)'(m_lvl),
         1'(m_lvl == D), 1'(m_lvl == 0), 1'(m_lvl >= AF), 1'(m_lvl <= AE),
         1'(m_ovf), 1'(m_udf)};
    return v;
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {W_ADDR, R_ADDR, LEVEL, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
            OVERFLOW, UNDERFLOW};
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_lvl = 0; m_ovf = 0; m_udf = 0;
  endtask

  // Driver: present one cycle of inputs, update the model, and queue the
  // expected post-edge outputs.
  task automatic step(input bit wen, input bit ren, input bit clr, input string tag);
    bit full, empty, wok, rok;
    @(negedge CLK);
    WEN = wen; REN = ren; CLR = clr;
    full  = (m_lvl == D);
    empty = (m_lvl == 0);
    if (clr) begin
      model_reset();
    end else begin
      wok = wen && !full;
      rok = ren && !empty;
      if (wen && full)  m_ovf = 1;
      if (ren && empty) m_udf = 1;
      if (wok) m_w = (m_w + 1) % D;
      if (rok) m_r = (m_r + 1) % D;
      m_lvl = m_lvl + int'(wok) - int'(rok);
    end
    exp_q.push_back(model_vec());
    tag_q.push_back(tag);
  endtask

  task automatic check_now(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (waddr,raddr,level,full,empty,af,ae,ovf,udf)",
               tag, act, exp);
    end
  endtask

  task automatic check_int(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Monitor: the outputs are valid every cycle, so compare one entry after each edge
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      check_now(tag_q.pop_front(), dut_vec(), exp_q.pop_front());
    end
  end

  initial begin
    // Reset state
    #12;
    check_now("reset", dut_vec(), model_vec());
    check_now("reset_const", dut_vec(), {3'd0, 3'd0, 4'd0, 6'b010100});
    @(negedge CLK);
    RST_N = 1'b1;

    // Fill 6 entries, then drain 6 entries. Thresholds are exercised at every level.
    for (int i = 0; i < D; i++) step(1, 0, 0, $sformatf("fill_%0d", i));
    for (int i = 0; i < D; i++) step(0, 1, 0, $sformatf("drain_%0d", i));
    @(posedge CLK); #2;
    check_int("drain_raddr_wrapped", int'(R_ADDR), 0);
    check_int("drain_empty", int'(EMPTY), 1);

    // Overflow while full, a read keeps the flag sticky, then CLR clears it
    for (int i = 0; i < D; i++) step(1, 0, 0, "ovf_fill");
    step(1, 0, 0, "ovf_write_full");
    step(0, 1, 0, "ovf_sticky_read");
    step(0, 0, 1, "ovf_clr");

    // Underflow on empty, then write and read together while empty
    step(0, 1, 0, "udf_read_empty");
    step(1, 1, 0, "wr_rd_on_empty");
    @(posedge CLK); #2;
    check_int("wr_rd_empty_level", int'(LEVEL), 1);
    check_int("wr_rd_empty_raddr", int'(R_ADDR), 0);

    // Hold level 3 for 10 simultaneous write+read cycles
    step(1, 0, 0, "to_lvl2");
    step(1, 0, 0, "to_lvl3");
    for (int i = 0; i < 10; i++) step(1, 1, 0, $sformatf("steady_%0d", i));
    @(posedge CLK); #2;
    check_int("steady_waddr", int'(W_ADDR), 1);   // (3 + 10) mod 6
    check_int("steady_raddr", int'(R_ADDR), 4);   // 10 mod 6
    check_int("steady_level", int'(LEVEL), 3);

    // Assert reset asynchronously in the middle of a burst at level 4
    step(0, 0, 1, "pre_rst_clr");
    for (int i = 0; i < 4; i++) step(1, 0, 0, "pre_rst_fill");
    @(negedge CLK);
    WEN = 1'b1; REN = 1'b0; CLR = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    check_now("async_reset", dut_vec(), model_vec());
    @(negedge CLK);
    WEN = 1'b0;
    RST_N = 1'b1;

    // CLR together with WEN while full: the write is ignored and no overflow is set
    for (int i = 0; i < D; i++) step(1, 0, 0, "clr_fill");
    step(1, 0, 1, "clr_with_wen");
    step(0, 0, 0, "idle");

    // Wait for the queue to drain, with a cycle limit
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
